// File: rtl/sensirion_frame_parser_if.sv
// Byte-stream handshake between the I2C master (producer) and the frame parser (consumer).
interface sensirion_frame_parser_if;
  logic       byte_valid;
  logic [7:0] byte_data;
  logic       byte_ready;

  modport master (output byte_valid, output byte_data, input byte_ready);
  modport slave  (input byte_valid, input byte_data, output byte_ready);
endinterface

// File: rtl/sensirion_frame_parser.sv
// Splits a Sensirion-style byte stream into {MSB, LSB, CRC} words and verifies each
// word with a bit-serial CRC-8, publishing words, per-word valid flags and error stats.
module sensirion_frame_parser #(
  parameter int unsigned NUM_WORDS = 2,
  parameter logic [7:0]  CRC_POLY  = 8'h31,
  parameter logic [7:0]  CRC_INIT  = 8'hFF,
  parameter bit          CRC_CHECK = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      frame_start,
  sensirion_frame_parser_if.slave   bus,
  output logic [4:0]                bytes_expected,
  output logic [16*NUM_WORDS-1:0]   words_out,
  output logic [NUM_WORDS-1:0]      word_valid,
  output logic                      word_strobe,
  output logic [2:0]                word_index,
  output logic                      crc_error,
  output logic [7:0]                error_count,
  output logic                      frame_done,
  output logic                      frame_ok
);

  typedef enum logic [2:0] {
    WAIT_MSB, SHIFT_MSB, WAIT_LSB, SHIFT_LSB, WAIT_CRC, DONE
  } state_t;

  localparam logic [2:0] LAST_IDX = 3'(NUM_WORDS - 1);

  state_t               state, state_nxt;
  logic [7:0]           crc, msb, lsb, crc_shift;
  logic [2:0]           bit_cnt;
  logic                 accept, crc_ok, last_word;
  logic [NUM_WORDS-1:0] cur_mask, valid_nxt;

  assign bytes_expected = 5'(3 * NUM_WORDS);
  assign accept    = bus.byte_valid & bus.byte_ready & ~frame_start;
  assign crc_shift = crc[7] ? ({crc[6:0], 1'b0} ^ CRC_POLY) : {crc[6:0], 1'b0};
  assign crc_ok    = !CRC_CHECK || (bus.byte_data == crc);
  assign last_word = (word_index == LAST_IDX);
  assign cur_mask  = NUM_WORDS'(1) << word_index;
  // Includes the word being judged now so frame_ok sees the final result.
  assign valid_nxt = word_valid | (crc_ok ? cur_mask : '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= WAIT_MSB;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (frame_start) begin
      state_nxt = WAIT_MSB;
    end else begin
      case (state)
        WAIT_MSB:  if (accept) state_nxt = SHIFT_MSB;
        SHIFT_MSB: if (bit_cnt == 3'd7) state_nxt = WAIT_LSB;
        WAIT_LSB:  if (accept) state_nxt = SHIFT_LSB;
        SHIFT_LSB: if (bit_cnt == 3'd7) state_nxt = WAIT_CRC;
        WAIT_CRC:  if (accept) state_nxt = last_word ? DONE : WAIT_MSB;
        default:   state_nxt = state;
      endcase
    end
  end

  always_comb begin
    bus.byte_ready = 1'b0;
    case (state)
      WAIT_MSB, WAIT_LSB, WAIT_CRC: bus.byte_ready = 1'b1;
      default:                      bus.byte_ready = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      crc         <= '0;
      msb         <= '0;
      lsb         <= '0;
      bit_cnt     <= '0;
      words_out   <= '0;
      word_valid  <= '0;
      word_strobe <= 1'b0;
      word_index  <= '0;
      crc_error   <= 1'b0;
      error_count <= '0;
      frame_done  <= 1'b0;
      frame_ok    <= 1'b0;
    end else begin
      word_strobe <= 1'b0;
      crc_error   <= 1'b0;
      frame_done  <= 1'b0;
      if (frame_start) begin
        word_index <= '0;
        word_valid <= '0;
        frame_ok   <= 1'b0;
        bit_cnt    <= '0;
      end else begin
        case (state)
          WAIT_MSB: if (accept) begin
            crc     <= CRC_INIT ^ bus.byte_data;
            msb     <= bus.byte_data;
            bit_cnt <= '0;
          end
          SHIFT_MSB, SHIFT_LSB: begin
            crc     <= crc_shift;
            bit_cnt <= bit_cnt + 3'd1;
          end
          WAIT_LSB: if (accept) begin
            crc     <= crc ^ bus.byte_data;
            lsb     <= bus.byte_data;
            bit_cnt <= '0;
          end
          WAIT_CRC: if (accept) begin
            if (crc_ok) begin
              for (int unsigned i = 0; i < NUM_WORDS; i++)
                if (word_index == 3'(i)) words_out[16*i +: 16] <= {msb, lsb};
              word_valid  <= valid_nxt;
              word_strobe <= 1'b1;
            end else begin
              crc_error <= 1'b1;
              if (error_count != '1) error_count <= error_count + 8'd1;
            end
            if (last_word) begin
              frame_done <= 1'b1;
              frame_ok   <= &valid_nxt;
            end else begin
              word_index <= word_index + 3'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: doc/sensirion_frame_parser.md
Name: sensirion_frame_parser

Overview:
Parametrised successor to the single-purpose SHT40 byte parser. Accepts the byte stream delivered by the I2C master and splits it into NUM_WORDS frames of {MSB, LSB, CRC}. Each word is checked with a bit-serial CRC-8 engine whose polynomial and init value are parameters. It publishes the words, per-word valid flags, frame completion and error statistics, so any Sensirion-style sensor can reuse it.

Parameters:
NUM_WORDS, 2, number of 16-bit words per frame (1..8)
CRC_POLY, 8'h31, CRC-8 polynomial (MSB-first, x^8 implicit)
CRC_INIT, 8'hFF, CRC register init value per word
CRC_CHECK, 1, 1 = enforce checksum; 0 = accept every word, never flag errors

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
frame_start  in  1  pulse: abort any frame in progress, re-arm for word 0
byte_valid  in  1  byte_data valid this cycle
byte_data  in  8  received I2C byte
byte_ready  out  1  parser accepts a byte this cycle
bytes_expected  out  5  constant 3*NUM_WORDS, drives the master's read count
words_out  out  16*NUM_WORDS  word i at [16*i+15:16*i]
word_valid  out  NUM_WORDS  bit i set when word i of the current frame passed CRC
word_strobe  out  1  one-cycle pulse when a word is written to words_out
word_index  out  3  index of the word currently being parsed
crc_error  out  1  one-cycle pulse on checksum mismatch
error_count  out  8  saturating mismatch counter since reset
frame_done  out  1  one-cycle pulse after the last checksum byte
frame_ok  out  1  level: last completed frame had all words valid

Behaviour:
- Reset (async, rst=1): state WAIT_MSB, word_index 0, all other outputs and registers 0, byte_ready 1.
- A byte is accepted on a rising edge with byte_valid & byte_ready. A byte_valid while byte_ready=0 is dropped with no effect.
- States: WAIT_MSB, SHIFT_MSB, WAIT_LSB, SHIFT_LSB, WAIT_CRC, DONE. byte_ready=1 only in the WAIT_* states.
- WAIT_MSB accept: crc <= CRC_INIT ^ byte, msb latched, bit counter 0, next SHIFT_MSB.
- SHIFT_*: 8 cycles, one bit per cycle. crc <= crc[7] ? (crc<<1)^CRC_POLY : crc<<1. After the 8th shift go to WAIT_LSB (from SHIFT_MSB) or WAIT_CRC (from SHIFT_LSB). byte_ready is therefore low for exactly 8 cycles after each data byte.
- WAIT_LSB accept: crc <= crc ^ byte, lsb latched, next SHIFT_LSB.
- WAIT_CRC accept, when byte == crc or CRC_CHECK=0:
  - words_out[word_index] <= {msb,lsb}
  - word_valid[word_index] <= 1
  - word_strobe pulses the next cycle
- WAIT_CRC accept, on mismatch (CRC_CHECK=1):
  - words_out[word_index] is unchanged and word_valid stays clear
  - crc_error pulses
  - error_count increments, saturating at 255
  - parsing continues with the next word; no abort.
- After the checksum byte:
  - If word_index == NUM_WORDS-1: go to DONE, frame_done pulses, frame_ok <= &word_valid (including the current result).
  - Otherwise word_index++ and go to WAIT_MSB.
- DONE: byte_ready=0, all bytes ignored. Leave only via frame_start.
- frame_start (any state) has priority over byte_valid in the same cycle; that byte is dropped. Effects: next state WAIT_MSB, word_index 0, word_valid cleared, frame_ok cleared, shift aborted. words_out and error_count are retained.
- Latency:
  - word_strobe, crc_error and frame_done are registered and assert the cycle after the CRC byte is accepted.
  - Minimum frame length is 19*NUM_WORDS cycles.
- Mid-operation reset: immediate return to reset values, including error_count.
- bytes_expected is combinational constant 3*NUM_WORDS.

Test Plan:
- NUM_WORDS=2, bytes BE EF 92 BE EF 92 at max rate -> two word_strobe pulses, words_out=32'hBEEF_BEEF, word_valid=2'b11, frame_done pulse, frame_ok=1, error_count=0.
- Bytes BE EF 00 BE EF 92 -> crc_error pulse after byte 3, word_valid=2'b10, words_out[15:0] unchanged, frame_ok=0, error_count=1.
- Assert byte_valid continuously after BE -> byte_ready low exactly 8 cycles and the intervening bytes are dropped; the frame still completes correctly once bytes are resent at ready.
- frame_start after the first two bytes, then a full valid frame -> word_index back to 0, prior partial word discarded, frame_ok=1.
- 260 bad-CRC words, then rst pulse during SHIFT_LSB -> error_count holds 255 before reset, all outputs 0 and byte_ready=1 immediately after reset.
- CRC_CHECK=0, bytes 12 34 FF -> words_out[15:0]=16'h1234, word_valid[0]=1, no crc_error.
